input_rd_arbiter: RTL and testbench

Shares one AXI4 read-only master port between C_NUM_REQ independent read masters, such as the NFA and query readers of an input channel, so they can issue bursts concurrently instead of being time-multiplexed by a top-level state machine. Address requests are granted round-robin and registered onto the shared AR channel. The requester index of every granted burst is queued in order, and R beats are steered back to the owner of the oldest outstanding burst. The block sits between the per-stream read masters and the kernel's m_axi port.

---
 rtl/input_rd_arbiter_if.sv | 48 ++++
 rtl/input_rd_arbiter.sv | 157 +++++++++++++++
 tb/tb_input_rd_arbiter.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/input_rd_arbiter_if.sv
// Bundle of the per-requester AR/R channels, the shared m_axi read port and status.
interface input_rd_arbiter_if #(
    parameter int unsigned C_NUM_REQ          = 2,
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 64,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 512,
    parameter int unsigned C_MAX_OUTSTANDING  = 8
);
    localparam int unsigned OCC_W = $clog2(C_MAX_OUTSTANDING) + 1;

    logic [C_NUM_REQ-1:0]                    s_arvalid;
    logic [C_NUM_REQ-1:0]                    s_arready;
    logic [C_NUM_REQ*C_M_AXI_ADDR_WIDTH-1:0] s_araddr;
    logic [C_NUM_REQ*8-1:0]                  s_arlen;
    logic [C_NUM_REQ-1:0]                    s_rvalid;
    logic [C_NUM_REQ-1:0]                    s_rready;
    logic [C_M_AXI_DATA_WIDTH-1:0]           s_rdata;
    logic                                    s_rlast;

    logic                                    m_axi_arvalid;
    logic                                    m_axi_arready;
    logic [C_M_AXI_ADDR_WIDTH-1:0]           m_axi_araddr;
    logic [7:0]                              m_axi_arlen;
    logic                                    m_axi_rvalid;
    logic                                    m_axi_rready;
    logic [C_M_AXI_DATA_WIDTH-1:0]           m_axi_rdata;
    logic                                    m_axi_rlast;

    logic [OCC_W-1:0]                        outstanding;
    logic                                    idle;

    // Arbiter side
    modport slave (
        input  s_arvalid, s_araddr, s_arlen, s_rready,
        input  m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rlast,
        output s_arready, s_rvalid, s_rdata, s_rlast,
        output m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_rready,
        output outstanding, idle
    );

    // Requester / memory side
    modport master (
        output s_arvalid, s_araddr, s_arlen, s_rready,
        output m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rlast,
        input  s_arready, s_rvalid, s_rdata, s_rlast,
        input  m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_rready,
        input  outstanding, idle
    );
endinterface

// File: rtl/input_rd_arbiter.sv
// Round-robin sharing of one AXI4 read port among C_NUM_REQ read masters.
// AR requests are registered onto the shared port; an in-order route FIFO of
// requester indices steers R beats back to the owner of the oldest burst.
module input_rd_arbiter #(
    parameter int unsigned C_NUM_REQ          = 2,
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 64,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 512,
    parameter int unsigned C_MAX_OUTSTANDING  = 8
) (
    input  logic              aclk,
    input  logic              areset,
    input_rd_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(C_NUM_REQ);
    localparam int unsigned PTR_W = $clog2(C_MAX_OUTSTANDING);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam int unsigned AW    = C_M_AXI_ADDR_WIDTH;

    typedef enum logic {AR_IDLE, AR_BUSY} ar_state_t;

    ar_state_t         state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  grant_q;
    logic [IDX_W-1:0]  grant_idx;
    logic              grant_found;
    logic [IDX_W:0]    cand;
    logic [AW-1:0]     sel_addr;
    logic [7:0]        sel_len;
    logic              ar_push;
    logic              r_pop;

    logic [IDX_W-1:0]  route_q [C_MAX_OUTSTANDING];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  count;
    logic [IDX_W-1:0]  head;
    logic              fifo_full;
    logic              fifo_empty;

    assign fifo_full  = (count == OCC_W'(C_MAX_OUTSTANDING));
    assign fifo_empty = (count == '0);
    assign head       = route_q[rd_ptr];

    // First requesting index at or after rr_ptr, wrapping modulo C_NUM_REQ
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 0; k < C_NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(C_NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(C_NUM_REQ);
            end
            if (!grant_found && bus.s_arvalid[IDX_W'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

    // Address/length of the winning requester
    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        for (int unsigned i = 0; i < C_NUM_REQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                sel_addr = bus.s_araddr[i*AW +: AW];
                sel_len  = bus.s_arlen[i*8 +: 8];
            end
        end
    end

    // Grant only from AR_IDLE with FIFO room; m_axi_arready never reaches here
    assign ar_push = (state == AR_IDLE) && grant_found && !fifo_full && !areset;

    // One-hot AR ready to the granted requester
    always_comb begin
        bus.s_arready = '0;
        if (ar_push) begin
            bus.s_arready[grant_idx] = 1'b1;
        end
    end

    // Zero-latency R steering to the owner of the oldest burst
    always_comb begin
        bus.s_rvalid     = '0;
        bus.m_axi_rready = 1'b0;
        if (!fifo_empty) begin
            bus.s_rvalid[head] = bus.m_axi_rvalid;
            bus.m_axi_rready   = bus.s_rready[head];
        end
    end

    assign bus.s_rdata       = bus.m_axi_rdata;
    assign bus.s_rlast       = bus.m_axi_rlast;
    assign r_pop             = bus.m_axi_rvalid && bus.m_axi_rready && bus.m_axi_rlast;
    assign bus.m_axi_arvalid = (state == AR_BUSY);
    assign bus.outstanding   = count;
    assign bus.idle          = fifo_empty && (state == AR_IDLE);

    // AR FSM: capture the grant, hold it on the shared port until accepted
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state            <= AR_IDLE;
            rr_ptr           <= '0;
            grant_q          <= '0;
            bus.m_axi_araddr <= '0;
            bus.m_axi_arlen  <= '0;
        end else begin
            case (state)
                AR_IDLE: begin
                    if (ar_push) begin
                        grant_q          <= grant_idx;
                        bus.m_axi_araddr <= sel_addr;
                        bus.m_axi_arlen  <= sel_len;
                        state            <= AR_BUSY;
                    end
                end
                AR_BUSY: begin
                    if (bus.m_axi_arready) begin
                        state  <= AR_IDLE;
                        rr_ptr <= (grant_q == IDX_W'(C_NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
                    end
                end
                default: state <= AR_IDLE;
            endcase
        end
    end

    // Route FIFO storage (contents are don't-care while empty)
    always_ff @(posedge aclk) begin
        if (ar_push) begin
            route_q[wr_ptr] <= grant_idx;
        end
    end

    // Route FIFO pointers and occupancy
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (ar_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (r_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({ar_push, r_pop})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_input_rd_arbiter.sv
// Randomized bench for input_rd_arbiter against a queue-based reference model.
module tb_input_rd_arbiter;
    localparam int unsigned N   = 2;
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned MAX = 4;

    typedef struct {
        int             own;
        logic [AW-1:0]  addr;
        logic [7:0]     len;
    } burst_t;

    logic aclk = 1'b0;
    logic areset;
    always #5 aclk = ~aclk;

    input_rd_arbiter_if #(
        .C_NUM_REQ(N), .C_M_AXI_ADDR_WIDTH(AW),
        .C_M_AXI_DATA_WIDTH(DW), .C_MAX_OUTSTANDING(MAX)
    ) bus ();

    input_rd_arbiter #(
        .C_NUM_REQ(N), .C_M_AXI_ADDR_WIDTH(AW),
        .C_M_AXI_DATA_WIDTH(DW), .C_MAX_OUTSTANDING(MAX)
    ) dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: AR arbitration state and in-order owner queue
    int             rr;
    bit             busy;
    int             cur_g;
    logic [AW-1:0]  cur_addr;
    logic [7:0]     cur_len;
    int             owners[$];

    // Requesters and their expected bursts
    bit             pend[N];
    logic [AW-1:0]  req_addr[N];
    logic [7:0]     req_len[N];
    int             rbeat[N];
    burst_t         pend_q[$];

    // Memory behind the shared port
    burst_t         mem_q[$];
    int             mem_beat;
    bit             mrv;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_model();
        rr = 0; busy = 1'b0; cur_g = 0; cur_addr = '0; cur_len = '0;
        owners.delete(); pend_q.delete(); mem_q.delete();
        mem_beat = 0; mrv = 1'b0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; req_addr[i] = '0; req_len[i] = '0; rbeat[i] = 0;
        end
        bus.s_arvalid = '0; bus.s_araddr = '0; bus.s_arlen = '0; bus.s_rready = '0;
        bus.m_axi_arready = 1'b0; bus.m_axi_rvalid = 1'b0;
        bus.m_axi_rdata = '0; bus.m_axi_rlast = 1'b0;
    endtask

    function automatic bit roll(input int pct);
        return int'($urandom % 100) < pct;
    endfunction

    // One clock: drive, check against model, advance model, step to next edge + 1
    task automatic do_cycle(input int p_req, input int p_ardy, input int p_rv, input int p_rr);
        int            g;
        int            idx;
        logic [N-1:0]  exp_arready;
        logic [N-1:0]  exp_rvalid;
        logic          exp_rready;
        bit            was_busy;
        bit            hs_r;
        burst_t        b;

        for (int i = 0; i < N; i++) begin
            if (!pend[i] && roll(p_req)) begin
                pend[i]     = 1'b1;
                req_addr[i] = AW'($urandom);
                req_len[i]  = 8'($urandom_range(0, 3));
            end
            bus.s_arvalid[i]         = pend[i];
            bus.s_araddr[i*AW +: AW] = req_addr[i];
            bus.s_arlen[i*8 +: 8]    = req_len[i];
            bus.s_rready[i]          = roll(p_rr);
        end
        bus.m_axi_arready = roll(p_ardy);
        if (mem_q.size() > 0) begin
            if (!mrv) mrv = roll(p_rv);
            bus.m_axi_rvalid = mrv;
            bus.m_axi_rdata  = DW'(mem_q[0].addr + AW'(mem_beat));
            bus.m_axi_rlast  = (mem_beat == int'(mem_q[0].len));
        end else begin
            mrv = 1'b0;
            bus.m_axi_rvalid = (owners.size() == 0) && roll(5);
            bus.m_axi_rdata  = DW'($urandom);
            bus.m_axi_rlast  = 1'($urandom);
        end
        #1;

        g = -1;
        if (!busy && owners.size() < MAX) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && pend[(rr + k) % N]) g = (rr + k) % N;
            end
        end
        exp_arready = '0;
        if (g >= 0) exp_arready[g] = 1'b1;
        exp_rvalid = '0;
        exp_rready = 1'b0;
        if (owners.size() > 0) begin
            exp_rvalid[owners[0]] = bus.m_axi_rvalid;
            exp_rready            = bus.s_rready[owners[0]];
        end

        check_eq("s_arready",     bus.s_arready,     exp_arready);
        check_eq("m_axi_arvalid", bus.m_axi_arvalid, busy);
        check_eq("m_axi_araddr",  bus.m_axi_araddr,  cur_addr);
        check_eq("m_axi_arlen",   bus.m_axi_arlen,   cur_len);
        check_eq("outstanding",   bus.outstanding,   owners.size());
        check_eq("idle",          bus.idle,          (owners.size() == 0) && !busy);
        check_eq("s_rvalid",      bus.s_rvalid,      exp_rvalid);
        check_eq("m_axi_rready",  bus.m_axi_rready,  exp_rready);
        check_eq("s_rdata",       bus.s_rdata,       bus.m_axi_rdata);
        check_eq("s_rlast",       bus.s_rlast,       bus.m_axi_rlast);

        // Each requester sees its own bursts, in order, complete
        for (int i = 0; i < N; i++) begin
            if (bus.s_rvalid[i] && bus.s_rready[i]) begin
                idx = -1;
                for (int j = 0; j < pend_q.size(); j++) begin
                    if (idx < 0 && pend_q[j].own == i) idx = j;
                end
                if (idx < 0) begin
                    check_eq("r_unexpected_beat", bus.s_rvalid[i], 0);
                end else begin
                    b = pend_q[idx];
                    check_eq("r_beat_data", bus.s_rdata, DW'(b.addr + AW'(rbeat[i])));
                    check_eq("r_beat_last", bus.s_rlast, rbeat[i] == int'(b.len));
                    if (rbeat[i] == int'(b.len)) begin
                        pend_q.delete(idx);
                        rbeat[i] = 0;
                    end else begin
                        rbeat[i]++;
                    end
                end
            end
        end

        was_busy = busy;
        hs_r     = bus.m_axi_rvalid && bus.m_axi_rready;
        if (owners.size() > 0 && hs_r && bus.m_axi_rlast) void'(owners.pop_front());
        if (mem_q.size() > 0 && hs_r) begin
            if (mem_beat == int'(mem_q[0].len)) begin
                void'(mem_q.pop_front());
                mem_beat = 0;
            end else begin
                mem_beat++;
            end
            mrv = 1'b0;
        end
        if (g >= 0) begin
            owners.push_back(g);
            busy = 1'b1; cur_g = g; cur_addr = req_addr[g]; cur_len = req_len[g];
            pend[g] = 1'b0;
            b.own = g; b.addr = req_addr[g]; b.len = req_len[g];
            pend_q.push_back(b);
        end
        if (was_busy && bus.m_axi_arready) begin
            busy = 1'b0;
            rr   = (cur_g + 1) % N;
            b.own = cur_g; b.addr = cur_addr; b.len = cur_len;
            mem_q.push_back(b);
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_s_arready"},   bus.s_arready,     0);
        check_eq({tag, "_s_rvalid"},    bus.s_rvalid,      0);
        check_eq({tag, "_arvalid"},     bus.m_axi_arvalid, 0);
        check_eq({tag, "_araddr"},      bus.m_axi_araddr,  0);
        check_eq({tag, "_arlen"},       bus.m_axi_arlen,   0);
        check_eq({tag, "_rready"},      bus.m_axi_rready,  0);
        check_eq({tag, "_outstanding"}, bus.outstanding,   0);
        check_eq({tag, "_idle"},        bus.idle,          1);
    endtask

    initial begin
        areset = 1'b1;
        clear_model();
        repeat (2) @(posedge aclk);
        #1;
        check_reset_outputs("por");
        @(negedge aclk);
        areset = 1'b0;
        @(posedge aclk);
        #1;

        // Saturating demand, no read data: alternating grants until full
        repeat (40)  do_cycle(100, 100, 0, 100);
        // Mixed traffic
        repeat (600) do_cycle(60, 70, 60, 70);
        // Heavy R backpressure
        repeat (400) do_cycle(90, 90, 90, 25);
        // Tight pipeline: frequent simultaneous grant and pop
        repeat (400) do_cycle(100, 100, 100, 100);

        // Reach AR_BUSY with three bursts outstanding, then reset mid-cycle
        for (int c = 0; c < 3000 && !(busy && owners.size() == 3); c++) do_cycle(80, 10, 15, 80);
        check_eq("pre_reset_outstanding", bus.outstanding,   3);
        check_eq("pre_reset_arvalid",     bus.m_axi_arvalid, 1);
        #2;
        areset = 1'b1;
        #1;
        check_reset_outputs("async");
        clear_model();
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        @(posedge aclk);
        #1;

        // Both request at once after reset: requester 0 must win
        pend[0] = 1'b1; req_addr[0] = AW'('h1000); req_len[0] = 8'd3;
        pend[1] = 1'b1; req_addr[1] = AW'('h2000); req_len[1] = 8'd0;
        bus.s_arvalid = 2'b11;
        bus.s_araddr  = {req_addr[1], req_addr[0]};
        bus.s_arlen   = {req_len[1], req_len[0]};
        #1;
        check_eq("first_grant_after_reset", bus.s_arready, 2'b01);
        repeat (600) do_cycle(70, 80, 70, 80);

        // Drain whatever is still in flight
        for (int c = 0; c < 500 && (owners.size() > 0 || busy); c++) do_cycle(0, 100, 100, 100);
        check_eq("final_idle", bus.idle, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
